// File: rtl/niossoc_key_debounce.sv
// Two-flop synchronizer plus per-channel stability counter for the board push-buttons.
// key_out feeds the button PIO; press/release_pulse are single-cycle strobes for fabric logic.
module niossoc_key_debounce #(
    parameter int unsigned WIDTH           = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned CNT_W           = 20,
    parameter bit          ACTIVE_LOW      = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] key_raw,
    output logic [WIDTH-1:0] key_out,
    output logic [WIDTH-1:0] press,
    // "release" is a reserved word, hence the suffix
    output logic [WIDTH-1:0] release_pulse
);

    localparam logic [WIDTH-1:0] IDLE    = {WIDTH{ACTIVE_LOW}};
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];
    logic [WIDTH-1:0] key_d;
    logic [WIDTH-1:0] press_d;
    logic [WIDTH-1:0] release_d;

    // Next-state: any matching cycle clears the count, so only an unbroken run qualifies.
    always_comb begin
        key_d     = key_out;
        press_d   = '0;
        release_d = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            cnt_d[i] = cnt_q[i];
        end
        for (int i = 0; i < int'(WIDTH); i++) begin
            if (sync2[i] == key_out[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_MAX) begin
                key_d[i] = sync2[i];
                cnt_d[i] = '0;
                if (sync2[i] != IDLE[i]) begin
                    press_d[i] = 1'b1;
                end else begin
                    release_d[i] = 1'b1;
                end
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    // State and output registers; strobes land in the same cycle as the new key_out level.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1         <= IDLE;
            sync2         <= IDLE;
            key_out       <= IDLE;
            press         <= '0;
            release_pulse <= '0;
            for (int i = 0; i < int'(WIDTH); i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1         <= key_raw;
            sync2         <= sync1;
            key_out       <= key_d;
            press         <= press_d;
            release_pulse <= release_d;
            for (int i = 0; i < int'(WIDTH); i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

endmodule

// File: tb/tb_niossoc_key_debounce.sv
// Directed bench for niossoc_key_debounce with an 8-cycle debounce window, active-low keys.
module tb_niossoc_key_debounce;

    logic       clk;
    logic       reset;
    logic [3:0] key_raw;
    logic [3:0] key_out;
    logic [3:0] press;
    logic [3:0] release_pulse;

    int checks = 0;
    int fails  = 0;

    niossoc_key_debounce #(
        .WIDTH           (4),
        .DEBOUNCE_CYCLES (8),
        .CNT_W           (4),
        .ACTIVE_LOW      (1'b1)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .key_raw       (key_raw),
        .key_out       (key_out),
        .press         (press),
        .release_pulse (release_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
        checks++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, got, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [3:0] k, input logic [3:0] p,
                           input logic [3:0] r);
        chk({tag, ".key_out"}, key_out, k);
        chk({tag, ".press"}, press, p);
        chk({tag, ".release"}, release_pulse, r);
    endtask

    // Apply raw, then expect the transition exactly n edges after the first sampling edge.
    task automatic watch(input string tag, input logic [3:0] raw, input int n,
                         input logic [3:0] k_before, input logic [3:0] k_after,
                         input logic [3:0] p_exp, input logic [3:0] r_exp);
        key_raw = raw;
        for (int j = 0; j <= n; j++) begin
            tick();
            if (j < n) chk_all($sformatf("%s.e%0d", tag, j), k_before, 4'b0000, 4'b0000);
            else       chk_all($sformatf("%s.e%0d", tag, j), k_after, p_exp, r_exp);
        end
        tick();
        chk_all({tag, ".after"}, k_after, 4'b0000, 4'b0000);
    endtask

    initial begin
        reset   = 1'b1;
        key_raw = 4'b0000;

        // 1. reset with keys reading pressed
        for (int j = 0; j < 3; j++) begin
            tick();
            chk_all($sformatf("rst.c%0d", j), 4'b1111, 4'b0000, 4'b0000);
        end
        reset   = 1'b0;
        key_raw = 4'b1111;
        tick();
        chk_all("rst.post", 4'b1111, 4'b0000, 4'b0000);

        // 2. clean press and release on ch0
        watch("press0", 4'b1110, 9, 4'b1111, 4'b1110, 4'b0001, 4'b0000);
        watch("rel0", 4'b1111, 9, 4'b1110, 4'b1111, 4'b0000, 4'b0001);

        // 3a. ch1 glitch of 7 cycles never qualifies
        key_raw = 4'b1101;
        for (int j = 0; j < 7; j++) begin
            tick();
            chk_all($sformatf("gl7.lo%0d", j), 4'b1111, 4'b0000, 4'b0000);
        end
        key_raw = 4'b1111;
        for (int j = 0; j < 12; j++) begin
            tick();
            chk_all($sformatf("gl7.hi%0d", j), 4'b1111, 4'b0000, 4'b0000);
        end

        // 3b. 8 low cycles qualify; raw returns high right after
        key_raw = 4'b1101;
        for (int j = 0; j < 8; j++) tick();
        key_raw = 4'b1111;
        tick();
        chk_all("gl8.e8", 4'b1111, 4'b0000, 4'b0000);
        tick();
        chk_all("gl8.e9", 4'b1101, 4'b0010, 4'b0000);
        for (int j = 1; j <= 8; j++) begin
            tick();
            if (j < 8) chk_all($sformatf("gl8.r%0d", j), 4'b1101, 4'b0000, 4'b0000);
            else       chk_all("gl8.rel", 4'b1111, 4'b0000, 4'b0010);
        end

        // 4. ch2 bounces every 3 cycles for 30 cycles, then settles low
        for (int s = 0; s < 10; s++) begin
            key_raw = (s % 2 == 0) ? 4'b1011 : 4'b1111;
            for (int j = 0; j < 3; j++) begin
                tick();
                chk_all($sformatf("bnc.s%0d.%0d", s, j), 4'b1111, 4'b0000, 4'b0000);
            end
        end
        watch("bnc.settle", 4'b1011, 9, 4'b1111, 4'b1011, 4'b0100, 4'b0000);
        for (int j = 0; j < 5; j++) begin
            tick();
            chk_all($sformatf("bnc.hold%0d", j), 4'b1011, 4'b0000, 4'b0000);
        end
        watch("bnc.rel", 4'b1111, 9, 4'b1011, 4'b1111, 4'b0000, 4'b0100);

        // 5. ch0 and ch3 together
        watch("sim.press", 4'b0110, 9, 4'b1111, 4'b0110, 4'b1001, 4'b0000);
        watch("sim.rel", 4'b1111, 9, 4'b0110, 4'b1111, 4'b0000, 4'b1001);

        // 6. reset while ch0 count is at 5, key kept held
        key_raw = 4'b1110;
        for (int j = 0; j < 7; j++) begin
            tick();
            chk_all($sformatf("mid.c%0d", j), 4'b1111, 4'b0000, 4'b0000);
        end
        reset = 1'b1;
        tick();
        chk_all("mid.rst0", 4'b1111, 4'b0000, 4'b0000);
        tick();
        chk_all("mid.rst1", 4'b1111, 4'b0000, 4'b0000);
        reset = 1'b0;
        watch("mid.requal", 4'b1110, 9, 4'b1111, 4'b1110, 4'b0001, 4'b0000);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
